// File: rtl/pom_tw_pkg.sv
// Shared definitions for the tw_info BRAM users: entry layout, ACK codes and arbiter states.
package pom_tw_pkg;

  localparam int unsigned TwEntryBytes = 16;

  // Bit positions inside one 128-bit tw_info entry.
  localparam int unsigned TwValidBit   = 7;
  localparam int unsigned TwAccIdLsb   = 8;
  localparam int unsigned TwAccIdMsb   = 12;
  localparam int unsigned TwCompLsb    = 32;
  localparam int unsigned TwCompMsb    = 63;
  localparam int unsigned TwTaskIdLsb  = 64;
  localparam int unsigned TwTaskIdMsb  = 127;

  localparam logic [7:0] TwAckOk     = 8'h01;
  localparam logic [7:0] TwAckReject = 8'h00;
  localparam logic [7:0] TwAckFinal  = 8'h02;

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1
  } arb_state_e;

endpackage

// File: rtl/pom_rr_arb2.sv
// Two-way round-robin grant FSM; a grant is held until the owner drops its request.
module pom_rr_arb2
  import pom_tw_pkg::*;
(
  input  logic clk,
  input  logic aresetn,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!req0) begin
          last_d  = 1'b0;
          state_d = req1 ? StOwn1 : StIdle;
        end
      end
      StOwn1: begin
        if (!req1) begin
          last_d  = 1'b1;
          state_d = req0 ? StOwn0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign gnt0 = (state_q == StOwn0);
  assign gnt1 = (state_q == StOwn1);

endmodule

// File: rtl/pom_tw_arb.sv
// Arbitrates the single tw_info BRAM port between the gateway (port 0) and taskwait unit (port 1).
module pom_tw_arb
  import pom_tw_pkg::*;
#(
  parameter int unsigned TW_INFO_SIZE = 16
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         req0,
  input  logic         req1,
  output logic         gnt0,
  output logic         gnt1,
  input  logic         p0_en,
  input  logic [15:0]  p0_we,
  input  logic [31:0]  p0_addr,
  input  logic [127:0] p0_din,
  output logic [127:0] p0_dout,
  output logic         p0_rvalid,
  input  logic         p1_en,
  input  logic [15:0]  p1_we,
  input  logic [31:0]  p1_addr,
  input  logic [127:0] p1_din,
  output logic [127:0] p1_dout,
  output logic         p1_rvalid,
  output logic         err,
  output logic         tw_info_clk,
  output logic         tw_info_en,
  output logic [15:0]  tw_info_we,
  output logic [31:0]  tw_info_addr,
  output logic [127:0] tw_info_din,
  input  logic [127:0] tw_info_dout
);

  localparam logic [31:0] MaxAddr = 32'(TW_INFO_SIZE * TwEntryBytes - TwEntryBytes);

  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr > MaxAddr) || (addr[3:0] != 4'h0);
  endfunction

  logic sel0, sel1, acc0, acc1, bad0, bad1, fwd0, fwd1, unauth;
  logic rd_pend_q, rd_pend_d, rd_port_q, err_q;

  pom_rr_arb2 u_rr (
    .clk    (clk),
    .aresetn(aresetn),
    .req0   (req0),
    .req1   (req1),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // An owner whose req is already low is in its release cycle; its en is dropped silently.
  assign sel0   = gnt0 & req0;
  assign sel1   = gnt1 & req1;
  assign acc0   = sel0 & p0_en;
  assign acc1   = sel1 & p1_en;
  assign bad0   = acc0 & addr_bad(p0_addr);
  assign bad1   = acc1 & addr_bad(p1_addr);
  assign fwd0   = acc0 & ~bad0;
  assign fwd1   = acc1 & ~bad1;
  assign unauth = (p0_en & ~gnt0) | (p1_en & ~gnt1);

  always_comb begin
    tw_info_en   = 1'b0;
    tw_info_we   = '0;
    tw_info_addr = '0;
    tw_info_din  = '0;
    if (gnt0) begin
      tw_info_en   = fwd0;
      tw_info_we   = fwd0 ? p0_we : '0;
      tw_info_addr = p0_addr;
      tw_info_din  = p0_din;
    end else if (gnt1) begin
      tw_info_en   = fwd1;
      tw_info_we   = fwd1 ? p1_we : '0;
      tw_info_addr = p1_addr;
      tw_info_din  = p1_din;
    end
  end

  assign rd_pend_d = (fwd0 && (p0_we == '0)) || (fwd1 && (p1_we == '0));

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_port_q <= fwd1;
      err_q     <= err_q | unauth | bad0 | bad1;
    end
  end

  // The read returns to its issuer even if the grant has since moved.
  assign p0_rvalid   = rd_pend_q & ~rd_port_q;
  assign p1_rvalid   = rd_pend_q & rd_port_q;
  assign p0_dout     = tw_info_dout;
  assign p1_dout     = tw_info_dout;
  assign err         = err_q;
  assign tw_info_clk = clk;

endmodule

// File: tb/tb_pom_tw_arb.sv
// Self-checking bench for pom_tw_arb: per-cycle vector table plus a read-return scoreboard.
module tb_pom_tw_arb;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         req0, req1, gnt0, gnt1;
  logic         p0_en, p1_en, p0_rvalid, p1_rvalid, err;
  logic [15:0]  p0_we, p1_we, tw_info_we;
  logic [31:0]  p0_addr, p1_addr, tw_info_addr;
  logic [127:0] p0_din, p1_din, p0_dout, p1_dout, tw_info_din, tw_info_dout;
  logic         tw_info_clk, tw_info_en;

  always #5 clk = ~clk;

  pom_tw_arb #(.TW_INFO_SIZE(16)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .req0        (req0),
    .req1        (req1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .p0_en       (p0_en),
    .p0_we       (p0_we),
    .p0_addr     (p0_addr),
    .p0_din      (p0_din),
    .p0_dout     (p0_dout),
    .p0_rvalid   (p0_rvalid),
    .p1_en       (p1_en),
    .p1_we       (p1_we),
    .p1_addr     (p1_addr),
    .p1_din      (p1_din),
    .p1_dout     (p1_dout),
    .p1_rvalid   (p1_rvalid),
    .err         (err),
    .tw_info_clk (tw_info_clk),
    .tw_info_en  (tw_info_en),
    .tw_info_we  (tw_info_we),
    .tw_info_addr(tw_info_addr),
    .tw_info_din (tw_info_din),
    .tw_info_dout(tw_info_dout)
  );

  typedef struct {
    bit rst, r0, r1, e0, e1;
    logic [15:0] w0, w1;
    logic [31:0] a0, a1;
    bit g0, g1, ten, er;
  } vec_t;

  typedef struct {
    int           port;
    logic [127:0] data;
    int           due;
  } sb_t;

  vec_t         vecs[$];
  sb_t          sb[$];
  logic [127:0] mem[16];
  logic [127:0] exp_mem[16];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;

  localparam logic [15:0] R = 16'h0000;
  localparam logic [15:0] W = 16'hFFFF;

  function automatic logic [127:0] pat(input int i);
    return {4{32'hA500_0000 | 32'(i)}};
  endfunction

  function automatic logic [127:0] din_of(input bit port, input logic [31:0] a);
    return {4{a ^ (port ? 32'h5A5A_0000 : 32'h3C3C_0000)}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit rst, r0, r1, e0, input logic [15:0] w0, input logic [31:0] a0,
                     input bit e1, input logic [15:0] w1, input logic [31:0] a1,
                     input bit g0, g1, ten, er);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
    v.w0 = w0; v.w1 = w1; v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.ten = ten; v.er = er;
    vecs.push_back(v);
  endtask

  // BRAM model with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tw_info_en) begin
      for (int b = 0; b < 16; b++)
        if (tw_info_we[b]) mem[tw_info_addr[7:4]][b*8 +: 8] <= tw_info_din[b*8 +: 8];
      if (tw_info_we == 16'h0) tw_info_dout <= mem[tw_info_addr[7:4]];
    end
  end

  // Read-return monitor: each expected read must come back exactly on its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      sb_t e;
      bit  x0, x1;
      x0 = 1'b0;
      x1 = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e  = sb.pop_front();
        x0 = (e.port == 0);
        x1 = (e.port == 1);
      end
      chk($sformatf("c%0d p0_rvalid", cyc), 128'(p0_rvalid), 128'(x0));
      chk($sformatf("c%0d p1_rvalid", cyc), 128'(p1_rvalid), 128'(x1));
      if (x0) chk($sformatf("c%0d p0_dout", cyc), p0_dout, e.data);
      if (x1) chk($sformatf("c%0d p1_dout", cyc), p1_dout, e.data);
    end
  end

  initial begin
    logic [15:0]  twe;
    logic [31:0]  taddr;
    logic [127:0] tdin;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = pat(i);
      exp_mem[i] = pat(i);
    end
    tw_info_dout = '0;
    aresetn = 1'b0; req0 = 0; req1 = 0; p0_en = 0; p1_en = 0;
    p0_we = '0; p1_we = '0; p0_addr = '0; p1_addr = '0; p0_din = '0; p1_din = '0;

    // add(rst, r0,r1, e0,w0,a0, e1,w1,a1, g0,g1,ten,err)
    // Tie after reset goes to port 0; port-0 en in its release cycle is dropped silently.
    add(0, 1,1, 0,R,0,     0,R,0,     0,0,0,0);
    add(0, 1,1, 0,R,0,     0,R,0,     1,0,0,0);
    add(0, 1,1, 1,R,'h30,  0,R,0,     1,0,1,0);
    add(0, 1,1, 0,R,0,     0,R,0,     1,0,0,0);
    add(0, 1,1, 0,R,0,     0,R,0,     1,0,0,0);
    add(0, 0,1, 1,R,'h40,  0,R,0,     1,0,0,0);
    add(0, 0,1, 0,R,0,     0,R,0,     0,1,0,0);
    add(0, 0,1, 0,R,0,     1,R,'h50,  0,1,1,0);
    add(0, 0,0, 0,R,0,     0,R,0,     0,1,0,0);
    add(0, 0,0, 0,R,0,     0,R,0,     0,0,0,0);
    add(0, 1,1, 0,R,0,     0,R,0,     0,0,0,0);
    add(0, 1,1, 0,R,0,     0,R,0,     1,0,0,0);
    add(0, 0,1, 0,R,0,     0,R,0,     1,0,0,0);
    add(0, 0,1, 0,R,0,     0,R,0,     0,1,0,0);
    // Port 1 final read, then handover to port 0.
    add(0, 1,1, 0,R,0,     1,R,'h60,  0,1,1,0);
    add(0, 1,0, 0,R,0,     0,R,0,     0,1,0,0);
    add(0, 1,0, 0,R,0,     0,R,0,     1,0,0,0);
    // Back-to-back reads and a write at the top entry.
    add(0, 1,0, 1,R,'h20,  0,R,0,     1,0,1,0);
    add(0, 1,0, 1,R,'h70,  0,R,0,     1,0,1,0);
    add(0, 1,0, 1,W,'hF0,  0,R,0,     1,0,1,0);
    add(0, 0,0, 0,R,0,     0,R,0,     1,0,0,0);
    add(0, 0,0, 0,R,0,     0,R,0,     0,0,0,0);
    add(0, 1,0, 0,R,0,     0,R,0,     0,0,0,0);
    add(0, 1,0, 1,R,'h20,  0,R,0,     1,0,1,0);
    // Unauthorized en from port 1 while port 0 reads.
    add(0, 1,0, 1,R,'h30,  1,R,'h10,  1,0,1,0);
    add(0, 1,0, 0,R,0,     0,R,0,     1,0,0,1);
    add(1, 0,0, 0,R,0,     0,R,0,     1,0,0,1);
    add(0, 0,0, 0,R,0,     0,R,0,     0,0,0,0);
    // Out-of-range write.
    add(0, 0,1, 0,R,0,     0,R,0,     0,0,0,0);
    add(0, 0,1, 0,R,0,     1,W,'h100, 0,1,0,0);
    add(0, 0,1, 0,R,0,     0,R,0,     0,1,0,1);
    add(1, 0,1, 0,R,0,     0,R,0,     0,1,0,1);
    // Highest legal entry reads back the earlier write; then a misaligned read.
    add(0, 0,1, 0,R,0,     0,R,0,     0,0,0,0);
    add(0, 0,1, 0,R,0,     1,R,'hF0,  0,1,1,0);
    add(0, 0,1, 0,R,0,     1,R,'h24,  0,1,0,0);
    add(0, 0,1, 0,R,0,     0,R,0,     0,1,0,1);
    add(1, 0,0, 0,R,0,     0,R,0,     0,1,0,1);
    add(0, 0,0, 0,R,0,     0,R,0,     0,0,0,0);
    // Reset during OWN1 with a read issued: read is discarded, grant drops.
    add(0, 0,1, 0,R,0,     0,R,0,     0,0,0,0);
    add(1, 0,1, 0,R,0,     1,R,'h10,  0,1,1,0);
    add(0, 0,1, 0,R,0,     0,R,0,     0,0,0,0);
    add(0, 0,1, 0,R,0,     0,R,0,     0,1,0,0);
    add(0, 0,0, 0,R,0,     0,R,0,     0,1,0,0);
    add(0, 0,0, 0,R,0,     0,R,0,     0,0,0,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset gnt0", 128'(gnt0), 128'(0));
    chk("reset gnt1", 128'(gnt1), 128'(0));
    chk("reset p0_rvalid", 128'(p0_rvalid), 128'(0));
    chk("reset p1_rvalid", 128'(p1_rvalid), 128'(0));
    chk("reset err", 128'(err), 128'(0));
    chk("reset tw_info_en", 128'(tw_info_en), 128'(0));
    chk("reset tw_info_we", 128'(tw_info_we), 128'(0));
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk);
      #1;
      aresetn = ~v.rst;
      req0 = v.r0; req1 = v.r1;
      p0_en = v.e0; p0_we = v.w0; p0_addr = v.a0; p0_din = din_of(1'b0, v.a0);
      p1_en = v.e1; p1_we = v.w1; p1_addr = v.a1; p1_din = din_of(1'b1, v.a1);
      taddr = v.g1 ? v.a1 : v.a0;
      twe   = v.ten ? (v.g1 ? v.w1 : v.w0) : 16'h0;
      tdin  = din_of(v.g1, taddr);
      if (v.ten && twe == 16'h0 && !v.rst)
        sb.push_back('{port: v.g1 ? 1 : 0, data: exp_mem[taddr[7:4]], due: cyc + 1});
      if (v.ten && twe != 16'h0) exp_mem[taddr[7:4]] = tdin;
      @(negedge clk);
      chk($sformatf("row%0d gnt0", i), 128'(gnt0), 128'(v.g0));
      chk($sformatf("row%0d gnt1", i), 128'(gnt1), 128'(v.g1));
      chk($sformatf("row%0d tw_info_en", i), 128'(tw_info_en), 128'(v.ten));
      chk($sformatf("row%0d tw_info_we", i), 128'(tw_info_we), 128'(twe));
      chk($sformatf("row%0d err", i), 128'(err), 128'(v.er));
      if (v.ten) begin
        chk($sformatf("row%0d tw_info_addr", i), 128'(tw_info_addr), 128'(taddr));
        chk($sformatf("row%0d tw_info_din", i), tw_info_din, tdin);
      end
    end

    repeat (2) @(negedge clk);
    chk("scoreboard drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
